// File: rtl/instr_loader.sv
// Program loader: streams instruction words into the CPU instruction memory and
// holds the CPU in reset until loading settles. Optional zero fill: INSTR_LOADER_ZERO_FILL_EN.
module instr_loader #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          HOLD_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       load_valid,
    input  logic [31:0]                load_data,
    input  logic                       load_last,
    output logic                       load_ready,
    output logic                       initialize,
    output logic [31:0]                instruction_initialize_data,
    output logic [31:0]                instruction_initialize_address,
    output logic                       cpu_rst,
    output logic                       done,
    output logic                       truncated,
    output logic [$clog2(DEPTH+1)-1:0] words_loaded
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
`ifdef INSTR_LOADER_ZERO_FILL_EN
    localparam logic [2:0] S_FILL = 3'd2;
`endif
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_RUN  = 3'd4;

    logic [2:0]    r_state;
    logic [31:0]   r_ptr;
    logic [31:0]   r_data;
    logic [31:0]   r_addr;
    logic          r_init;
    logic          r_cpu_rst;
    logic          r_done;
    logic          r_trunc;
    logic [CW-1:0] r_words;
    logic [HW-1:0] r_hold_cnt;
`ifdef INSTR_LOADER_ZERO_FILL_EN
    logic [CW-1:0] r_fidx;
`endif
    logic          w_load_ready;
    logic          w_accept;

    assign w_load_ready = (r_state == S_LOAD);
    assign w_accept     = load_valid & w_load_ready;

    // Loader state machine, write-port registers and CPU reset control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= BASE_ADDR;
            r_data     <= 32'h0;
            r_addr     <= BASE_ADDR;
            r_init     <= 1'b0;
            r_cpu_rst  <= 1'b1;
            r_done     <= 1'b0;
            r_trunc    <= 1'b0;
            r_words    <= '0;
            r_hold_cnt <= '0;
`ifdef INSTR_LOADER_ZERO_FILL_EN
            r_fidx     <= '0;
`endif
        end else begin
            r_init <= 1'b0;
            case (r_state)
                S_IDLE, S_RUN: begin
                    if (start) begin
                        r_state   <= S_LOAD;
                        r_ptr     <= BASE_ADDR;
                        r_words   <= '0;
                        r_trunc   <= 1'b0;
                        r_cpu_rst <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_init  <= 1'b1;
                        r_data  <= load_data;
                        r_addr  <= r_ptr;
                        r_ptr   <= r_ptr + 32'd4;
                        r_words <= r_words + CW'(1);
                        // A full memory without load_last ends the load as truncated
                        if (load_last || (r_words == LAST_IDX)) begin
                            r_trunc    <= ~load_last;
                            r_hold_cnt <= '0;
`ifdef INSTR_LOADER_ZERO_FILL_EN
                            if (r_words == LAST_IDX) begin
                                r_state <= S_HOLD;
                            end else begin
                                r_state <= S_FILL;
                                r_fidx  <= r_words + CW'(1);
                            end
`else
                            r_state <= S_HOLD;
`endif
                        end
                    end
                end
`ifdef INSTR_LOADER_ZERO_FILL_EN
                S_FILL: begin
                    r_init <= 1'b1;
                    r_data <= 32'h0;
                    r_addr <= r_ptr;
                    r_ptr  <= r_ptr + 32'd4;
                    r_fidx <= r_fidx + CW'(1);
                    if (r_fidx == LAST_IDX) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                    end
                end
`endif
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state   <= S_RUN;
                        r_cpu_rst <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cpu_rst <= 1'b1;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    assign load_ready                     = w_load_ready;
    assign initialize                     = r_init;
    assign instruction_initialize_data    = r_data;
    assign instruction_initialize_address = r_addr;
    assign cpu_rst                        = r_cpu_rst;
    assign done                           = r_done;
    assign truncated                      = r_trunc;
    assign words_loaded                   = r_words;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: the driver predicts every memory write,
// a negedge monitor matches each initialize pulse against the prediction.
module tb_instr_loader;

    localparam int DEPTH = 8;
    localparam int HOLD  = 4;
    localparam int CW    = $clog2(DEPTH + 1);
`ifdef INSTR_LOADER_ZERO_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = 32'h0;
    logic          load_last = 1'b0;
    logic          load_ready;
    logic          initialize;
    logic [31:0]   init_data;
    logic [31:0]   init_addr;
    logic          cpu_rst;
    logic          done;
    logic          truncated;
    logic [CW-1:0] words_loaded;

    instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .initialize(initialize),
        .instruction_initialize_data(init_data),
        .instruction_initialize_address(init_addr),
        .cpu_rst(cpu_rst), .done(done), .truncated(truncated),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;

    // model state
    bit          m_loading = 1'b0;
    logic [31:0] m_ptr = 32'h0;
    int          m_words = 0;
    bit          m_trunc = 1'b0;
    int          m_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write pulse must match the oldest prediction in its cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (initialize) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("write_cycle", cyc, q[0].tag);
                    chk("write_addr", init_addr, q[0].addr);
                    chk("write_data", init_data, q[0].data);
                    void'(q.pop_front());
                end
            end else if (q.size() != 0 && q[0].tag <= cyc) begin
                chk("missing_write", 32'd0, 32'd1);
                void'(q.pop_front());
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        m_loading = 1'b1;
        m_ptr     = 32'h0;
        m_words   = 0;
        m_trunc   = 1'b0;
        chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("start_done", {31'd0, done}, 32'd0);
        chk("start_trunc", {31'd0, truncated}, 32'd0);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic l);
        bit acc;
        int hold_entry;
        load_valid = v;
        load_data  = d;
        load_last  = l;
        @(negedge clk);
        chk("load_ready", {31'd0, load_ready}, {31'd0, m_loading});
        acc = v && m_loading;
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (acc) begin
            q.push_back('{tag: cyc, addr: m_ptr, data: d});
            m_ptr   = m_ptr + 32'd4;
            m_words = m_words + 1;
            if (l || m_words == DEPTH) begin
                m_loading  = 1'b0;
                m_trunc    = !l;
                hold_entry = cyc;
                if (FILL && m_words < DEPTH) begin
                    for (int j = 0; j < DEPTH - m_words; j++)
                        q.push_back('{tag: cyc + 1 + j, addr: m_ptr + 32'(4 * j), data: 32'h0});
                    hold_entry = cyc + (DEPTH - m_words);
                end
                m_run = hold_entry + HOLD;
            end
        end
    endtask

    task automatic wait_run();
        int guard;
        guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (cyc < m_run) begin
                chk("hold_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            end else begin
                chk("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
                chk("run_done", {31'd0, done}, 32'd1);
                chk("run_words", 32'(words_loaded), 32'(m_words));
                chk("run_trunc", {31'd0, truncated}, {31'd0, m_trunc});
                break;
            end
        end
        if (guard >= 200) chk("run_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init", {31'd0, initialize}, 32'd0);
        chk("rst_data", init_data, 32'h0);
        chk("rst_addr", init_addr, 32'h0);
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // three words back to back
        do_start();
        drive(1'b1, 32'hAAAA_0001, 1'b0);
        drive(1'b1, 32'hBBBB_0002, 1'b0);
        drive(1'b1, 32'hCCCC_0003, 1'b1);
        wait_run();

        // restart from RUN with source gaps 1,0,0,1,1
        do_start();
        drive(1'b1, 32'h1111_1111, 1'b0);
        drive(1'b0, 32'hDEAD_BEEF, 1'b1);
        drive(1'b0, 32'hDEAD_BEEF, 1'b0);
        drive(1'b1, 32'h2222_2222, 1'b0);
        drive(1'b1, 32'h3333_3333, 1'b1);
        wait_run();

        // DEPTH+1 words without load_last: truncation, last one refused
        do_start();
        for (int i = 0; i <= DEPTH; i++) drive(1'b1, 32'h5000_0000 + 32'(i), 1'b0);
        wait_run();

        // two-word reload clears truncated
        do_start();
        drive(1'b1, 32'h0000_00A1, 1'b0);
        drive(1'b1, 32'h0000_00A2, 1'b1);
        wait_run();

        // async reset right after the second accept
        do_start();
        drive(1'b1, 32'h7777_0001, 1'b0);
        load_valid = 1'b1;
        load_data  = 32'h7777_0002;
        @(posedge clk); #2;
        rst = 1'b1;
        load_valid = 1'b0;
        #1;
        chk("arst_init", {31'd0, initialize}, 32'd0);
        chk("arst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("arst_ready", {31'd0, load_ready}, 32'd0);
        chk("arst_addr", init_addr, 32'h0);
        chk("arst_words", 32'(words_loaded), 32'd0);
        q.delete();
        m_loading = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_start();
        drive(1'b1, 32'h8888_0001, 1'b1);
        wait_run();

        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader sitting directly upstream of the single-cycle CPU. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the CPU's instruction memory through the CPU's `initialize` / `instruction_initialize_data` / `instruction_initialize_address` port. It holds the CPU in reset while loading and for a fixed settle period afterwards, then releases it to run. It also supports reload on demand.

## Interface
- `DEPTH`, 64: maximum words loaded; instruction memory capacity in words (≥2).
- `BASE_ADDR`, 32'h0: byte address of first word.
- `HOLD_CYCLES`, 4: cycles `cpu_rst` stays high after the last write (≥1).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a load; sampled in IDLE and RUN only.
- `load_valid`  in  1  source has a word.
- `load_data`  in  32  instruction word.
- `load_last`  in  1  qualifies the final word of the program.
- `load_ready`  out  1  loader accepts a word this cycle.
- `initialize`  out  1  to CPU; write strobe for instruction memory.
- `instruction_initialize_data`  out  32  to CPU; write data.
- `instruction_initialize_address`  out  32  to CPU; byte write address.
- `cpu_rst`  out  1  to CPU `rst`; active-high.
- `done`  out  1  high while in RUN.
- `truncated`  out  1  sticky: DEPTH words accepted without `load_last`.
- `words_loaded`  out  $clog2(DEPTH+1)  words accepted in the current/last load.

## Operation
- States: IDLE, LOAD, FILL (see Configuration), HOLD, RUN.
- Reset values: state IDLE, `initialize`=0, data=0, address=`BASE_ADDR`, `cpu_rst`=1, `load_ready`=0, `done`=0, `truncated`=0, `words_loaded`=0.
- IDLE: `cpu_rst`=1. `start` → LOAD. Address pointer ← `BASE_ADDR`, `words_loaded` ← 0, `truncated` ← 0.
- LOAD: `load_ready`=1 (combinational from state). Accept = `load_valid & load_ready`. On accept: data/address registers ← `load_data`/pointer, pointer += 4, `words_loaded` += 1.
  - Accept with `load_last` → HOLD (or FILL).
  - Accept of word number DEPTH without `load_last` → `truncated` ← 1, → HOLD (or FILL). Further words are not accepted.
- HOLD: `load_ready`=0, `cpu_rst`=1. Counter runs HOLD_CYCLES cycles, then → RUN.
- RUN: `cpu_rst`=0, `done`=1. `start` → LOAD with IDLE's initialisation. `cpu_rst` rises at the same edge.
- `start` in LOAD/FILL/HOLD is ignored. `load_last` without `load_valid` is ignored.
- Address arithmetic is 32-bit modulo 2^32. Pointer wrap is not checked.

## Timing
- Write latency is 1 cycle. A word accepted at edge k drives `initialize`=1, data and address during cycle k+1, so the CPU's memory captures it at edge k+1.
- `initialize` is high for exactly one cycle per write. Back-to-back accepts give continuous `initialize` with addresses incrementing by 4. Source gaps give `initialize`=0 cycles, and data/address hold their last value.
- The final write's `initialize` pulse falls in the first HOLD/FILL cycle. `cpu_rst` stays 1 throughout.
- `cpu_rst` falls at the edge entering RUN: exactly HOLD_CYCLES cycles after the HOLD-entry edge.
- Async `rst` mid-load: all outputs return to reset values immediately. Partial memory contents are left as is. The next load restarts at `BASE_ADDR`.

## Configuration
- `INSTR_LOADER_ZERO_FILL_EN` defined:
  - After the last accepted word, enter FILL. `load_ready`=0.
  - Write 32'h0 to each remaining address up to word DEPTH-1, one per cycle with `initialize`=1, then go to HOLD.
  - If DEPTH words were already loaded, FILL is skipped.
  - `words_loaded` counts source words only.
- Not defined: FILL does not exist. LOAD goes directly to HOLD, and stale memory beyond the program is untouched.

## Test plan
- Reset then `start`; send 3 words A,B,C back-to-back, `load_last` on C → `initialize` high 3 consecutive cycles at addresses 0,4,8 with A,B,C. `words_loaded`=3. `cpu_rst` falls 4 cycles after C's accept edge. `done`=1.
- `load_valid` toggling 1,0,0,1,1 → exactly 3 `initialize` pulses, aligned 1 cycle after each accept. Addresses 0,4,8. No pulse in gap cycles.
- DEPTH=4, 5 words sent without `load_last` → 4 writes (0..12), `truncated`=1, 5th word never accepted (`load_ready`=0). Goes to RUN.
- Async `rst` asserted mid-cycle after the 2nd accept → `initialize`=0, `cpu_rst`=1, state IDLE immediately. A new `start` writes its first word to address 0.
- In RUN, pulse `start`, load 2 words → `cpu_rst`=1 next cycle, `done`=0, writes at 0,4, `truncated` cleared, RUN re-entered.
- With `INSTR_LOADER_ZERO_FILL_EN`, DEPTH=8, 3 words → 8 total `initialize` pulses. Addresses 12..28 carry 32'h0. `words_loaded`=3.
